// File: rtl/eoc_monitor.sv
// eoc_monitor: watches NUM_CH asynchronous end-of-computation flags.
// For each channel it records that the channel has finished and captures
// that channel's return code. Once every channel has reported, the monitor
// decides PASS or FAIL. It decides TIMEOUT if the run exceeds a programmable
// cycle limit before every channel has reported.
module eoc_monitor #(
    parameter int NUM_CH      = 3,
    parameter int CODE_W      = 8,
    parameter int TIMEOUT_W   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic [NUM_CH-1:0]        done_i,
    input  logic [NUM_CH*CODE_W-1:0] code_i,
    input  logic [TIMEOUT_W-1:0]     timeout_i,
    output logic [2:0]               state_o,
    output logic [NUM_CH-1:0]        done_mask_o,
    output logic [1:0]               exit_status_o,
    output logic [CODE_W-1:0]        exit_code_o,
    output logic [TIMEOUT_W-1:0]     elapsed_o,
    output logic                     finish_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam logic [TIMEOUT_W-1:0] ONE_T = TIMEOUT_W'(1);

    // Lowest-index nonzero code among the packed channel codes, or 0.
    function automatic logic [CODE_W-1:0] first_nonzero(input logic [NUM_CH*CODE_W-1:0] codes);
        logic [CODE_W-1:0] res;
        res = {CODE_W{1'b0}};
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (codes[k*CODE_W +: CODE_W] != {CODE_W{1'b0}}) begin
                res = codes[k*CODE_W +: CODE_W];
            end
        end
        return res;
    endfunction

    // Status encoding that belongs to a given state.
    function automatic logic [1:0] status_of(input state_e st);
        logic [1:0] res;
        case (st)
            ST_PASS:    res = 2'b01;
            ST_FAIL:    res = 2'b10;
            ST_TIMEOUT: res = 2'b11;
            default:    res = 2'b00;
        endcase
        return res;
    endfunction

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  done_s;

    state_e                     state_q, state_d;
    logic [NUM_CH-1:0]          mask_q, mask_d;
    logic [NUM_CH*CODE_W-1:0]   codes_q, codes_d;
    logic [CODE_W-1:0]          exit_code_q, exit_code_d;
    logic [TIMEOUT_W-1:0]       elapsed_q, elapsed_d;
    logic [1:0]                 status_q, status_d;
    logic                       finish_q, finish_d;
    logic                       timeout_hit_s;
    logic                       terminal_d_s;

    // Multi-flop synchroniser for the asynchronous done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], done_i};
        end
    end

    assign done_s = sync_q[SYNC_STAGES-1];

    // Limit reached after timeout_i RUN cycles; a zero limit never fires.
    assign timeout_hit_s = (timeout_i != {TIMEOUT_W{1'b0}}) && (elapsed_q == (timeout_i - ONE_T));

    // Next-state, sticky mask / code capture and output decode.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        codes_d     = codes_q;
        exit_code_d = exit_code_q;
        elapsed_d   = elapsed_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !clear_i) begin
                    state_d     = ST_RUN;
                    mask_d      = {NUM_CH{1'b0}};
                    codes_d     = {(NUM_CH*CODE_W){1'b0}};
                    exit_code_d = {CODE_W{1'b0}};
                    elapsed_d   = {TIMEOUT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else begin
                    elapsed_d = (&elapsed_q) ? elapsed_q : (elapsed_q + ONE_T);
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (done_s[k] && !mask_q[k]) begin
                            mask_d[k]                     = 1'b1;
                            codes_d[k*CODE_W +: CODE_W]   = code_i[k*CODE_W +: CODE_W];
                        end else begin
                            mask_d[k] = mask_q[k];
                        end
                    end
                    // Completion is checked before timeout so it wins a tie.
                    if (&mask_d) begin
                        if (codes_d != {(NUM_CH*CODE_W){1'b0}}) begin
                            state_d     = ST_FAIL;
                            exit_code_d = first_nonzero(codes_d);
                        end else begin
                            state_d = ST_PASS;
                        end
                    end else if (timeout_hit_s) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        terminal_d_s = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
        finish_d     = (state_q == ST_RUN) && terminal_d_s;
        status_d     = status_of(state_d);
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            codes_q     <= '0;
            exit_code_q <= '0;
            elapsed_q   <= '0;
            status_q    <= 2'b00;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            codes_q     <= codes_d;
            exit_code_q <= exit_code_d;
            elapsed_q   <= elapsed_d;
            status_q    <= status_d;
            finish_q    <= finish_d;
        end
    end

    assign state_o       = state_q;
    assign done_mask_o   = mask_q;
    assign exit_status_o = status_q;
    assign exit_code_o   = exit_code_q;
    assign elapsed_o     = elapsed_q;
    assign finish_o      = finish_q;

endmodule

// File: tb/tb_eoc_monitor.sv
// Scoreboard bench for eoc_monitor (NUM_CH=3, CODE_W=8, SYNC_STAGES=2).
module tb_eoc_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        clear_i;
    logic [2:0]  done_i;
    logic [23:0] code_i;
    logic [31:0] timeout_i;
    logic [2:0]  state_o;
    logic [2:0]  done_mask_o;
    logic [1:0]  exit_status_o;
    logic [7:0]  exit_code_o;
    logic [31:0] elapsed_o;
    logic        finish_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic prev_fin = 1'b0;

    typedef struct {
        logic [2:0]  st;
        logic [1:0]  es;
        logic [7:0]  code;
        logic [2:0]  mask;
        logic [31:0] el;
        int          at;
    } exp_t;

    exp_t sb[$];

    eoc_monitor #(.NUM_CH(3), .CODE_W(8), .TIMEOUT_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
        .done_i(done_i), .code_i(code_i), .timeout_i(timeout_i),
        .state_o(state_o), .done_mask_o(done_mask_o), .exit_status_o(exit_status_o),
        .exit_code_o(exit_code_o), .elapsed_o(elapsed_o), .finish_o(finish_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input logic [1:0] es, input logic [7:0] code,
                        input logic [2:0] mask, input logic [31:0] el, input int at);
        exp_t e;
        e.st = st; e.es = es; e.code = code; e.mask = mask; e.el = el; e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL finish_wait: got no finish_o expected %0d more results", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: on every finish_o pulse pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (rst_n && finish_o) begin
            exp_t e;
            chk("finish_single_cycle", prev_fin, 1'b0);
            if (sb.size() == 0) begin
                chk("unexpected_finish", finish_o, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("fin_state", state_o, e.st);
                chk("fin_status", exit_status_o, e.es);
                chk("fin_code", exit_code_o, e.code);
                chk("fin_mask", done_mask_o, e.mask);
                chk("fin_elapsed", elapsed_o, e.el);
                chk("fin_cycle", cyc, e.at);
            end
        end
        prev_fin = finish_o;
    end

    initial begin
        int s;
        int t;
        rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0; done_i = 3'b000;
        code_i = 24'h000000; timeout_i = 32'd0;
        #12;
        chk("rst_state", state_o, 3'd0);
        chk("rst_mask", done_mask_o, 3'b000);
        chk("rst_finish", finish_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step(2);

        // All channels pass with zero codes.
        s = cyc; start_i = 1'b1;
        step(1); start_i = 1'b0;
        chk("run_state", state_o, 3'd1);
        chk("run_status", exit_status_o, 2'b00);
        chk("run_elapsed0", elapsed_o, 32'd0);
        done_i[0] = 1'b1;
        step(4);
        chk("run_mask_ch0", done_mask_o, 3'b001);
        step(6); done_i[1] = 1'b1;
        step(10); done_i[2] = 1'b1; t = cyc;
        push(3'd2, 2'b01, 8'h00, 3'b111, 32'(t + 2 - s), t + 3);
        wait_sb(20);
        chk("hold_state", state_o, 3'd2);
        chk("hold_finish_low", finish_o, 1'b0);
        start_i = 1'b1; step(1); start_i = 1'b0;
        chk("start_ignored", state_o, 3'd2);
        clear_i = 1'b1; step(1); clear_i = 1'b0;
        chk("clear_to_idle", state_o, 3'd0);
        chk("idle_status", exit_status_o, 2'b00);

        // Nonzero codes produce FAIL with the lowest-index nonzero code.
        done_i = 3'b000; step(3);
        code_i = {8'h09, 8'h05, 8'h00};
        s = cyc; start_i = 1'b1; done_i = 3'b111;
        push(3'd3, 2'b10, 8'h05, 3'b111, 32'd2, s + 3);
        step(1); start_i = 1'b0;
        wait_sb(20);
        clear_i = 1'b1; step(1); clear_i = 1'b0;

        // Timeout after 100 RUN cycles with only channel 0 done.
        done_i = 3'b000; code_i = 24'h000000; timeout_i = 32'd100; step(3);
        s = cyc; start_i = 1'b1;
        push(3'd4, 2'b11, 8'h00, 3'b001, 32'd100, s + 101);
        step(1); start_i = 1'b0; done_i[0] = 1'b1;
        wait_sb(150);
        clear_i = 1'b1; step(1); clear_i = 1'b0;

        // Completion on the timeout edge wins over timeout.
        done_i = 3'b011; timeout_i = 32'd50; step(3);
        s = cyc; start_i = 1'b1;
        push(3'd2, 2'b01, 8'h00, 3'b111, 32'd50, s + 51);
        step(1); start_i = 1'b0;
        step(47); done_i[2] = 1'b1;
        wait_sb(20);
        clear_i = 1'b1; step(1); clear_i = 1'b0;

        // Abort mid-run, then a fresh start clears mask and elapsed.
        done_i = 3'b000; timeout_i = 32'd0; step(3);
        start_i = 1'b1; step(1); start_i = 1'b0; done_i = 3'b011;
        step(4);
        chk("abort_mask_before", done_mask_o, 3'b011);
        clear_i = 1'b1; step(1); clear_i = 1'b0;
        chk("abort_state", state_o, 3'd0);
        chk("abort_no_finish", finish_o, 1'b0);
        chk("abort_status", exit_status_o, 2'b00);
        done_i = 3'b000; step(3);
        start_i = 1'b1; step(1); start_i = 1'b0;
        chk("restart_mask", done_mask_o, 3'b000);
        chk("restart_elapsed", elapsed_o, 32'd0);
        chk("restart_state", state_o, 3'd1);

        // Asynchronous reset between edges mid-run.
        done_i = 3'b011; step(3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", state_o, 3'd0);
        chk("arst_mask", done_mask_o, 3'b000);
        chk("arst_elapsed", elapsed_o, 32'd0);
        chk("arst_status", exit_status_o, 2'b00);
        chk("arst_code", exit_code_o, 8'h00);
        done_i = 3'b111;
        @(posedge clk); #1;
        rst_n = 1'b1; start_i = 1'b1; s = cyc;
        push(3'd2, 2'b01, 8'h00, 3'b111, 32'd2, s + 3);
        step(1); start_i = 1'b0;
        wait_sb(20);
        clear_i = 1'b1; step(1); clear_i = 1'b0;
        step(2);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
